// File: rtl/ttl299_shift_register.sv
// 8-bit universal shift/storage register with a shared 3-state parallel bus (74LS299 style).
// Latency: one CLK edge for load/shift/reset; IO drive and release are combinational.
// Backpressure: none; the register acts on the S value present at every rising edge.
// Optional feature: define TTL299_SHIFT_COUNT_EN to add the SHIFT_COUNT / BYTE_DONE shift counter.
module ttl299_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       S,
    input  logic             OE1_n,
    input  logic             OE2_n,
    input  logic             DSR,
    input  logic             DSL,
    inout  wire  [WIDTH-1:0] IO,
    output logic             Q0,
    output logic             Q7
`ifdef TTL299_SHIFT_COUNT_EN
    ,
    output logic [2:0]       SHIFT_COUNT,
    output logic             BYTE_DONE
`endif
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    mode_t            mode;
    logic [WIDTH-1:0] internal_register;
    logic             bus_drive;

    assign mode = mode_t'(S);

    // Storage register: reset, hold, shift toward the MSB, shift toward the LSB, or load from the bus.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            internal_register <= '0;
        end else begin
            case (mode)
                MODE_HOLD: internal_register <= internal_register;
                MODE_SHR:  internal_register <= {internal_register[WIDTH-2:0], DSR};
                MODE_SHL:  internal_register <= {DSL, internal_register[WIDTH-1:1]};
                MODE_LOAD: internal_register <= IO;
                default:   internal_register <= internal_register;
            endcase
        end
    end

    // A load always releases the bus so the register samples the external driver, never itself.
    assign bus_drive = !OE1_n && !OE2_n && (mode != MODE_LOAD);
    assign IO        = bus_drive ? internal_register : {WIDTH{1'bz}};

    assign Q0 = internal_register[0];
    assign Q7 = internal_register[WIDTH-1];

`ifdef TTL299_SHIFT_COUNT_EN
    // Counts shifts modulo 8; the wrapping shift raises BYTE_DONE for the following cycle only.
    always_ff @(posedge CLK) begin
        if (RESET || (mode == MODE_LOAD)) begin
            SHIFT_COUNT <= 3'd0;
            BYTE_DONE   <= 1'b0;
        end else if ((mode == MODE_SHR) || (mode == MODE_SHL)) begin
            SHIFT_COUNT <= SHIFT_COUNT + 3'd1;
            BYTE_DONE   <= (SHIFT_COUNT == 3'd7);
        end else begin
            SHIFT_COUNT <= SHIFT_COUNT;
            BYTE_DONE   <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ttl299_shift_register.sv
// Directed bench for ttl299_shift_register with an arithmetic reference model.
// Inputs change 1 time unit after each rising edge; outputs are checked on the falling edge.
// A watchdog bounds the run.
module tb_ttl299_shift_register;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] S = 2'b00;
    logic       OE1_n = 1'b1;
    logic       OE2_n = 1'b1;
    logic       DSR = 1'b0;
    logic       DSL = 1'b0;
    logic       Q0;
    logic       Q7;
    wire  [7:0] io_bus;
    logic       ext_en = 1'b0;
    logic [7:0] ext_dat = 8'h00;
`ifdef TTL299_SHIFT_COUNT_EN
    logic [2:0] SHIFT_COUNT;
    logic       BYTE_DONE;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    int m_reg  = 0;
    int m_cnt  = 0;
    int m_done = 0;
    bit model_ok = 1'b0;

    assign io_bus = ext_en ? ext_dat : 8'bzzzzzzzz;

    ttl299_shift_register #(.WIDTH(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .S          (S),
        .OE1_n      (OE1_n),
        .OE2_n      (OE2_n),
        .DSR        (DSR),
        .DSL        (DSL),
        .IO         (io_bus),
        .Q0         (Q0),
        .Q7         (Q7)
`ifdef TTL299_SHIFT_COUNT_EN
        ,
        .SHIFT_COUNT(SHIFT_COUNT),
        .BYTE_DONE  (BYTE_DONE)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the register as a byte value; shifting toward the MSB doubles it, toward the LSB halves it.
    always @(posedge CLK) begin
        if (RESET) begin
            m_reg = 0; m_cnt = 0; m_done = 0; model_ok = 1'b1;
        end else begin
            case (S)
                2'b01: begin
                    m_done = (m_cnt == 7) ? 1 : 0;
                    m_reg  = (m_reg * 2 + int'(DSR)) % 256;
                    m_cnt  = (m_cnt + 1) % 8;
                end
                2'b10: begin
                    m_done = (m_cnt == 7) ? 1 : 0;
                    m_reg  = m_reg / 2 + 128 * int'(DSL);
                    m_cnt  = (m_cnt + 1) % 8;
                end
                2'b11: begin
                    m_reg = int'(ext_dat); m_cnt = 0; m_done = 0;
                end
                default: m_done = 0;
            endcase
        end
    end

    // Compare process: every falling edge once the model has been reset.
    always @(negedge CLK) begin
        if (model_ok) begin
            check("reg_model", 32'(dut.internal_register), 32'(m_reg));
            check("q0_model", 32'(Q0), 32'(m_reg % 2));
            check("q7_model", 32'(Q7), 32'(m_reg / 128));
            if (!OE1_n && !OE2_n && S != 2'b11 && !ext_en)
                check("io_drive_model", 32'(io_bus), 32'(m_reg));
            else if (!(!OE1_n && !OE2_n && S != 2'b11) && ext_en)
                check("io_release_model", 32'(io_bus), 32'(ext_dat));
`ifdef TTL299_SHIFT_COUNT_EN
            check("cnt_model", 32'(SHIFT_COUNT), 32'(m_cnt));
            check("done_model", 32'(BYTE_DONE), 32'(m_done));
`endif
        end
    end

    task automatic step(input logic [1:0] s_i, input logic dsr_i, input logic dsl_i);
        S = s_i; DSR = dsr_i; DSL = dsl_i;
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        ext_en = 1'b1; ext_dat = v;
        step(2'b11, 1'b0, 1'b0);
        ext_en = 1'b0;
        S = 2'b00;
    endtask

    // Directed mixed-operation table: {S, DSR, DSL}
    logic [3:0] ops [12] = '{4'b01_1_0, 4'b01_0_0, 4'b10_0_1, 4'b00_1_1, 4'b10_0_0, 4'b01_1_1,
                             4'b10_1_1, 4'b01_1_0, 4'b00_0_0, 4'b10_0_1, 4'b01_0_1, 4'b10_1_0};

    initial begin
        #20000;
        $display("FAIL watchdog: run did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge CLK); #1;

        // Reset with bus enabled
        RESET = 1'b1; OE1_n = 1'b0; OE2_n = 1'b0;
        step(2'b00, 1'b0, 1'b0);
        RESET = 1'b0;
        check("reset_reg", 32'(dut.internal_register), 32'h00);
        check("reset_q0", 32'(Q0), 32'h0);
        check("reset_q7", 32'(Q7), 32'h0);
        check("reset_io", 32'(io_bus), 32'h00);
        // Disabled output must leave an external value on the bus untouched
        OE1_n = 1'b1; ext_en = 1'b1; ext_dat = 8'h5A; #1;
        check("float_io", 32'(io_bus), 32'h5A);
        ext_en = 1'b0; OE1_n = 1'b0;

        // Parallel load with output enabled: no contention while S=11
        ext_en = 1'b1; ext_dat = 8'hAA;
        step(2'b11, 1'b0, 1'b0);
        check("load_reg", 32'(dut.internal_register), 32'hAA);
        check("load_io_ext", 32'(io_bus), 32'hAA);
        ext_en = 1'b0; ext_dat = 8'h00; S = 2'b00; #1;
        check("load_io_drive", 32'(io_bus), 32'hAA);

        // Shift right
        load(8'h81);
        step(2'b01, 1'b0, 1'b0);
        check("shr1_reg", 32'(dut.internal_register), 32'h02);
        check("shr1_q0", 32'(Q0), 32'h0);
        check("shr1_q7", 32'(Q7), 32'h0);
        step(2'b01, 1'b1, 1'b0);
        check("shr2_reg", 32'(dut.internal_register), 32'h05);

        // Shift left
        load(8'h81);
        step(2'b10, 1'b0, 1'b1);
        check("shl_reg", 32'(dut.internal_register), 32'hC0);
        check("shl_q7", 32'(Q7), 32'h1);
        check("shl_q0", 32'(Q0), 32'h0);

        // Hold, with S glitching between edges
        load(8'h3C);
        for (int i = 0; i < 3; i++) begin
            S = 2'b00;
            #1 S = 2'b01;
            #1 S = 2'b00;
            @(posedge CLK); #1;
        end
        check("hold_reg", 32'(dut.internal_register), 32'h3C);

        // Reset beats parallel load
        RESET = 1'b1; ext_en = 1'b1; ext_dat = 8'hFF;
        step(2'b11, 1'b0, 1'b0);
        RESET = 1'b0; ext_en = 1'b0;
        check("rst_prio_reg", 32'(dut.internal_register), 32'h00);

        // Mixed sequence checked by the model
        load(8'h96);
        for (int i = 0; i < 12; i++) step(ops[i][3:2], ops[i][1], ops[i][0]);

        // Counter: 8 right shifts after a load
        load(8'h5B);
        for (int i = 1; i <= 8; i++) begin
            step(2'b01, 1'b0, 1'b0);
`ifdef TTL299_SHIFT_COUNT_EN
            check("cnt_step", 32'(SHIFT_COUNT), 32'(i % 8));
            check("done_step", 32'(BYTE_DONE), (i == 8) ? 32'h1 : 32'h0);
`endif
        end
        check("shift8_reg", 32'(dut.internal_register), 32'h00);
        step(2'b00, 1'b0, 1'b0);
`ifdef TTL299_SHIFT_COUNT_EN
        check("done_clear", 32'(BYTE_DONE), 32'h0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        check("cnt_two", 32'(SHIFT_COUNT), 32'h2);
`endif
        load(8'h11);
`ifdef TTL299_SHIFT_COUNT_EN
        check("cnt_load_clr", 32'(SHIFT_COUNT), 32'h0);
`endif
        check("final_reg", 32'(dut.internal_register), 32'h11);

        step(2'b00, 1'b0, 1'b0);
        @(negedge CLK); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
